// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester APB master with a single outstanding transfer and PREADY timeout abort.
// Define APB_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with req0 winning.
module apb_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_gnt;
  logic              w_idle, w_gnt, w_acc, w_timeout;
  logic [DATA_W-1:0] w_rdata;
  assign w_idle = r_state == IDLE;
`ifdef APB_ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_gnt = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;
`else
  assign w_gnt = ~req0_valid;
`endif
  assign req0_ready = w_idle & req0_valid & ~w_gnt;
  assign req1_ready = w_idle & req1_valid & w_gnt;
  assign w_acc      = req0_ready | req1_ready;
  // abort on the wait cycle that would bring the counter to TIMEOUT_CYC
  assign w_timeout  = !PREADY && (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_rdata    = (PREADY && !PWRITE) ? PRDATA : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gnt      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
`ifdef APB_ARB_ROUND_ROBIN_EN
      r_last     <= 1'b1;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_state <= SETUP;
          r_cnt   <= '0;
          r_gnt   <= w_gnt;
          PSEL    <= 1'b1;
          PADDR   <= w_gnt ? req1_addr : req0_addr;
          PWDATA  <= w_gnt ? req1_wdata : req0_wdata;
          PWRITE  <= w_gnt ? req1_write : req0_write;
`ifdef APB_ARB_ROUND_ROBIN_EN
          r_last  <= w_gnt;
`endif
        end
        SETUP: begin
          r_state <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: if (PREADY || w_timeout) begin
          r_state <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (r_gnt) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= w_rdata;
            rsp1_err   <= !PREADY;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= w_rdata;
            rsp0_err   <= !PREADY;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_apb_master_arbiter;
  logic        clk = 0, rst = 0;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA = 0;
  logic        PSEL, PENABLE, PWRITE, PREADY = 0;
  typedef struct {int id; logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  apb_master_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp0_valid=%0b rsp1_valid=%0b expected none", rsp0_valid, rsp1_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_both", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
        chk("rsp_id", {31'd0, rsp1_valid}, e.id);
        chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp1_valid ? rsp1_err : rsp0_err}, {31'd0, e.err});
      end
    end
  end
  task automatic set_req(input int id, input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (id == 1) begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
  endtask
  // PREADY is held low for the first `waits` ACCESS cycles, then raised
  task automatic run_xfer(input string nm, input int id, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int waits, input logic exp_err, output int en_cnt, output int lat);
    logic rdy = 0, done = 0;
    int bad = 0;
    en_cnt = 0; lat = 0;
    PRDATA = rd; PREADY = 0;
    @(posedge clk); #1;
    set_req(id, 1, wr, a, d);
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = (id == 1) ? req1_ready : req0_ready;
    end
    chk({nm, "_ready"}, {31'd0, rdy}, 32'd1);
    chk({nm, "_other_ready"}, {31'd0, (id == 1) ? req0_ready : req1_ready}, 32'd0);
    if (!rdy) begin
      set_req(id, 0, 0, 0, 0);
      return;
    end
    sb.push_back('{id, (exp_err || wr) ? 32'd0 : rd, exp_err});
    @(posedge clk); #1;
    set_req(id, 0, 0, 0, 0);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && (!PSEL || PENABLE || req0_ready || req1_ready)) bad++;
      if (PENABLE) begin
        en_cnt++;
        PREADY = en_cnt > waits;
      end
      if (PSEL && (PADDR !== a || PWDATA !== d || PWRITE !== wr)) bad++;
      done = (id == 1) ? rsp1_valid : rsp0_valid;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_apb_bad"}, bad, 0);
    chk({nm, "_psel_after"}, {30'd0, PSEL, PENABLE}, 32'd0);
  endtask
  int en, lat, acc;
  int exp_gnt[4];
  initial begin
`ifdef APB_ARB_ROUND_ROBIN_EN
    exp_gnt = '{0, 1, 0, 1};
`else
    exp_gnt = '{0, 0, 0, 0};
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_apb", {PADDR[7:0], PWDATA[7:0], 13'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    // minimum write: accept, SETUP, ACCESS, response
    run_xfer("wr0", 0, 1, 32'h1, 32'h7, 32'hDEAD, 0, 0, en, lat);
    chk("wr0_en_cycles", en, 1);
    chk("wr0_latency", lat, 3);
    chk("idle_hold", {PADDR[15:0], PWDATA[15:0]}, {16'h1, 16'h7});
    // read with two wait states
    run_xfer("rd1", 1, 0, 32'h2, 32'h0, 32'h5, 2, 0, en, lat);
    chk("rd1_en_cycles", en, 3);
    chk("rd1_latency", lat, 5);
    // both requesters continuously valid
    @(posedge clk); #1;
    PREADY = 1;
    set_req(0, 1, 1, 32'h10, 32'h100);
    set_req(1, 1, 1, 32'h20, 32'h200);
    for (int k = 0; k < 4; k++) sb.push_back('{exp_gnt[k], 32'd0, 1'b0});
    acc = 0;
    for (int i = 0; i < 60 && acc < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk($sformatf("grant%0d", acc), {30'd0, req0_ready, req1_ready}, exp_gnt[acc] == 1 ? 32'd1 : 32'd2);
        acc++;
      end
    end
    chk("grant_count", acc, 4);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("grant_drain", sb.size(), 0);
    // PREADY never rises
    run_xfer("to0", 0, 0, 32'h3, 32'h0, 32'hAA, 1000, 1, en, lat);
    chk("to0_en_cycles", en, 16);
    // reset mid-ACCESS aborts silently
    @(posedge clk); #1;
    PREADY = 0;
    set_req(0, 1, 1, 32'h4, 32'h44);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge clk);
    chk("rst_in_access", {31'd0, PENABLE}, 32'd1);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_abort_apb", {30'd0, PSEL, PENABLE}, 32'd0);
    repeat (4) @(negedge clk);
    set_req(0, 1, 0, 32'h8, 32'h0);
    set_req(1, 1, 0, 32'h9, 32'h0);
    #1;
    chk("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    run_xfer("rd0", 0, 0, 32'h8, 32'h0, 32'h1234, 1, 0, en, lat);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, the maximum number of ACCESS cycles with PREADY=0 before a transfer is aborted.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: synchronous and active-low.
REQ-006 The block SHALL have ports req0_valid and req1_valid, input, 1 bit, each requester's transfer request.
REQ-007 The block SHALL have ports req0_write and req1_write, input, 1 bit, 1=write and 0=read.
REQ-008 The block SHALL have ports req0_addr and req1_addr, input, ADDR_W bits, the transfer address.
REQ-009 The block SHALL have ports req0_wdata and req1_wdata, input, DATA_W bits, the write data.
REQ-010 The block SHALL have ports req0_ready and req1_ready, output, 1 bit, request accepted when high together with valid.
REQ-011 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have ports rsp0_rdata and rsp1_rdata, output, DATA_W bits, the read data.
REQ-013 The block SHALL have ports rsp0_err and rsp1_err, output, 1 bit, the timeout-abort flag, qualified by rspN_valid.
REQ-014 The block SHALL have APB outputs PADDR (ADDR_W bits), PSEL (1 bit), PENABLE (1 bit), PWRITE (1 bit) and PWDATA (DATA_W bits).
REQ-015 The block SHALL have APB inputs PRDATA (DATA_W bits) and PREADY (1 bit).

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS, with a single outstanding transfer.
REQ-017 In IDLE, the block SHALL drive reqN_ready combinationally high only for the arbitration winner among the valid requesters; the other ready SHALL be 0.
REQ-018 On a clock edge with valid&ready, the block SHALL latch addr, wdata, write and the grant ID, and the FSM SHALL go to SETUP.
REQ-019 In SETUP, the block SHALL drive PSEL=1 and PENABLE=0 with PADDR/PWRITE/PWDATA from the latched values; the FSM SHALL always go to ACCESS on the next cycle.
REQ-020 In ACCESS, the block SHALL drive PSEL=1 and PENABLE=1, and PADDR/PWRITE/PWDATA SHALL be held stable.
REQ-021 In ACCESS with PREADY=1, the FSM SHALL go to IDLE; on the next cycle rspN_valid=1 for the granted requester, rspN_rdata=PRDATA sampled at that edge for a read or 0 for a write, and rspN_err=0.
REQ-022 In ACCESS, the wait counter SHALL increment on every PREADY=0 cycle; when it reaches TIMEOUT_CYC, the FSM SHALL go to IDLE and pulse rspN_valid=1 with rspN_err=1 and rspN_rdata=0.
REQ-023 The wait counter SHALL clear on entry to SETUP and SHALL be sized ceil(log2(TIMEOUT_CYC+1)) bits.
REQ-024 Minimum transfer SHALL be accept edge, SETUP, ACCESS with PREADY=1, then rsp pulse: three cycles from accept to the rsp pulse.
REQ-025 PSEL and PENABLE SHALL be 0 in IDLE; PADDR/PWDATA SHALL hold their last values in IDLE.
REQ-026 reqN_ready SHALL be 0 outside IDLE, and the block SHALL ignore reqN_valid outside IDLE.
REQ-027 rspN_valid SHALL pulse exactly once per accepted request; a new acceptance SHALL be allowed in the same cycle the rsp pulse is driven.

Reset
REQ-028 When rst=0 is sampled at a clock edge, the block SHALL enter IDLE and clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp*_valid, rsp*_rdata, rsp*_err and the wait counter, and set last_grant=1.
REQ-029 A reset during SETUP or ACCESS SHALL abort the transfer with no rsp pulse, and PSEL SHALL drop on the reset edge.

Configuration
REQ-030 With macro APB_ARB_ROUND_ROBIN_EN defined, when both requesters are valid the block SHALL grant the requester other than last_grant, and last_grant SHALL update on each acceptance.
REQ-031 Without APB_ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority with req0 always winning, and last_grant SHALL be unused.

Verification
REQ-032 The bench SHALL cover: req0 write addr=0x1, wdata=7, PREADY=1 -> SETUP then ACCESS with PADDR=1, PWDATA=7, PWRITE=1, rsp0_valid pulse 3 cycles after accept, rsp0_err=0.
REQ-033 The bench SHALL cover: req1 read addr=0x2, PREADY low for 2 ACCESS cycles, PRDATA=0x5 -> PENABLE held 3 cycles, rsp1_rdata=5, rsp1_err=0.
REQ-034 The bench SHALL cover: both valid continuously, 4 transfers, RR enabled -> grants 0,1,0,1; RR disabled -> grants 0,0,0,0.
REQ-035 The bench SHALL cover: PREADY stuck 0 -> abort after exactly 16 ACCESS cycles, rsp0_err=1, rsp0_rdata=0, PSEL=0 next cycle.
REQ-036 The bench SHALL cover: rst=0 during ACCESS -> PSEL=PENABLE=0 after that edge, no rsp pulse, then a req0 issued next is granted first.
